// File: rtl/op_stream_arbiter_if.sv
// Requester command/word handshakes plus the data_interface drive, shared by the
// op_stream_arbiter and whatever sits on either side of it.
interface op_stream_arbiter_if #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned LEN_W = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*LEN_W-1:0] req_exp;
  logic [NREQ*32-1:0]    word_data;
  logic [NREQ-1:0]       word_valid;
  logic [NREQ-1:0]       word_ready;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [31:0]           iface_data;
  logic                  iface_enable;

  // Arbiter side.
  modport slave (
    input  req_valid, req_len, req_exp, word_data, word_valid,
    output word_ready, grant, done, iface_data, iface_enable
  );

  // Requesters and data_interface side.
  modport master (
    output req_valid, req_len, req_exp, word_data, word_valid,
    input  word_ready, grant, done, iface_data, iface_enable
  );
endinterface

// File: rtl/op_stream_arbiter.sv
// Round-robin batch arbiter that frames each granted batch (optional expected-output
// header, op-count header, op/data words) onto the single data_interface port.
module op_stream_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned LEN_W = 16
) (
  input logic                clk,
  input logic                clear,
  input logic                enable,
  op_stream_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrExp,
    StHdrCnt,
    StStream,
    StDone
  } state_e;

  localparam logic [NREQ-1:0] GrantOne = {{(NREQ-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  done_q;
  logic [31:0]      iface_data_q;
  logic             iface_enable_q;
  logic [LEN_W:0]   words_left_q;
  logic             last_grant_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] exp_q;

  logic             winner;
  logic [LEN_W-1:0] win_len;
  logic [LEN_W-1:0] win_exp;
  logic [31:0]      cur_word;
  logic [NREQ-1:0]  word_ready;
  logic             handshake;

  // On a tie the requester that did not own the last batch wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req_valid == 2'b11) begin
      winner = ~last_grant_q;
    end else if (!bus.req_valid[0]) begin
      winner = 1'b1;
    end
    win_len = winner ? bus.req_len[2*LEN_W-1:LEN_W] : bus.req_len[LEN_W-1:0];
    win_exp = winner ? bus.req_exp[2*LEN_W-1:LEN_W] : bus.req_exp[LEN_W-1:0];
  end

  // last_grant_q always names the current owner while a batch is in flight.
  always_comb begin
    cur_word   = last_grant_q ? bus.word_data[63:32] : bus.word_data[31:0];
    word_ready = ((state_q == StStream) && enable) ? grant_q : '0;
    handshake  = |(word_ready & bus.word_valid);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q        <= StIdle;
      grant_q        <= '0;
      done_q         <= '0;
      iface_data_q   <= '0;
      iface_enable_q <= 1'b0;
      words_left_q   <= '0;
      last_grant_q   <= 1'b1;
      len_q          <= '0;
      exp_q          <= '0;
    end else begin
      done_q         <= '0;
      iface_enable_q <= 1'b0;
      iface_data_q   <= '0;
      if (enable) begin
        unique case (state_q)
          StIdle: begin
            if (|bus.req_valid) begin
              grant_q      <= GrantOne << winner;
              last_grant_q <= winner;
              len_q        <= win_len;
              exp_q        <= win_exp;
              state_q      <= (win_exp != '0) ? StHdrExp : StHdrCnt;
            end
          end
          StHdrExp: begin
            iface_data_q   <= 32'({4'h1, exp_q});
            iface_enable_q <= 1'b1;
            state_q        <= StHdrCnt;
          end
          StHdrCnt: begin
            iface_data_q   <= 32'({4'h0, len_q});
            iface_enable_q <= 1'b1;
            words_left_q   <= {len_q, 1'b0};
            state_q        <= (len_q != '0) ? StStream : StDone;
          end
          StStream: begin
            if (handshake) begin
              iface_data_q   <= cur_word;
              iface_enable_q <= 1'b1;
              words_left_q   <= words_left_q - 1'b1;
              if (words_left_q == (LEN_W+1)'(1)) begin
                state_q <= StDone;
              end
            end
          end
          StDone: begin
            done_q  <= grant_q;
            grant_q <= '0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.word_ready   = word_ready;
  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.iface_data   = iface_data_q;
  assign bus.iface_enable = iface_enable_q;

  assert property (@(posedge clk) $onehot0(grant_q));

endmodule

// File: tb/tb_op_stream_arbiter.sv
// Bench for op_stream_arbiter: table of single batches, hand-written corner sequences and
// randomized multi-batch traffic checked against a queue-based model of the framing rules.
module tb_op_stream_arbiter;
  localparam int unsigned LEN_W = 16;

  logic clk = 1'b0;
  logic clear;
  logic enable;
  always #5 clk = ~clk;

  op_stream_arbiter_if #(.NREQ(2), .LEN_W(LEN_W)) bus ();

  op_stream_arbiter #(.NREQ(2), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .clear  (clear),
    .enable (enable),
    .bus    (bus)
  );

  typedef struct {
    int len;
    int exp;
    int id;
  } batch_t;

  typedef struct {
    int          r;
    int          len;
    int          exp;
    logic [31:0] hdr;
    int          nwords;
    int          lat;
  } vec_t;

  batch_t      blist [2][64];
  int          head [2];
  int          cnt [2];
  int          widx [2];
  bit          hs [2];
  logic [31:0] exp_word [$];
  int          exp_who [$];
  int          exp_done [$];
  logic        hist_en [$];
  logic [31:0] hist_data [$];
  int          model_last;
  int          next_id;
  int          checks;
  int          errors;
  int          cyc;
  int          done_cyc;
  int          en_count;
  logic [31:0] first_word;

  function automatic void check(input bit ok, input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [31:0] gen(input int r, input int id, input int k);
    return {4'(r + 1), 12'(id), 16'(k)};
  endfunction

  function automatic void add_batch(input int r, input int len, input int exp);
    if (cnt[r] < 64) begin
      blist[r][cnt[r]] = '{len: len, exp: exp, id: next_id};
      cnt[r]++;
      next_id++;
    end
  endfunction

  // Expected framing for every pending batch, in round-robin batch order.
  function automatic void plan();
    int     h [2];
    int     w;
    batch_t b;
    exp_word.delete();
    exp_who.delete();
    exp_done.delete();
    h[0] = head[0];
    h[1] = head[1];
    while (h[0] < cnt[0] || h[1] < cnt[1]) begin
      if (h[0] < cnt[0] && h[1] < cnt[1]) w = 1 - model_last;
      else w = (h[0] < cnt[0]) ? 0 : 1;
      model_last = w;
      b = blist[w][h[w]];
      h[w]++;
      if (b.exp != 0) begin
        exp_word.push_back(32'h0001_0000 + 32'(b.exp));
        exp_who.push_back(w);
      end
      exp_word.push_back(32'(b.len));
      exp_who.push_back(w);
      for (int k = 0; k < 2 * b.len; k++) begin
        exp_word.push_back(gen(w, b.id, k));
        exp_who.push_back(w);
      end
      exp_done.push_back(w);
    end
  endfunction

  function automatic void abandon(input int r);
    if (head[r] < cnt[r]) head[r]++;
    widx[0] = 0;
    widx[1] = 0;
    hs[0] = 1'b0;
    hs[1] = 1'b0;
    exp_word.delete();
    exp_who.delete();
    exp_done.delete();
    model_last = 1;
  endfunction

  task automatic step(input int vprob, input int eprob, input bit clr);
    logic [31:0] w;
    int          who;
    int          d;
    batch_t      b;
    @(negedge clk);
    cyc++;
    hist_en.push_back(bus.iface_enable);
    hist_data.push_back(bus.iface_data);
    check($onehot0(bus.grant), "grant_onehot0", 32'(bus.grant), 32'h1);
    if (bus.iface_enable) begin
      en_count++;
      if (en_count == 1) first_word = bus.iface_data;
      if (exp_word.size() == 0) begin
        check(1'b0, "extra_word", bus.iface_data, 32'h0);
      end else begin
        w   = exp_word.pop_front();
        who = exp_who.pop_front();
        check(bus.iface_data == w, "stream_word", bus.iface_data, w);
        check(bus.grant == (2'b01 << who), "word_owner", 32'(bus.grant), 32'(2'b01 << who));
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (hs[r]) begin
        check(head[r] < cnt[r] && widx[r] < 2 * blist[r][head[r]].len, "pop_in_batch",
              32'(widx[r]), 32'(r));
        widx[r]++;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (bus.done[r]) begin
        done_cyc = cyc;
        if (exp_done.size() == 0 || head[r] >= cnt[r]) begin
          check(1'b0, "spurious_done", 32'(bus.done), 32'h0);
        end else begin
          d = exp_done.pop_front();
          check(d == r, "done_order", 32'(r), 32'(d));
          check(widx[r] == 2 * blist[r][head[r]].len, "done_words", 32'(widx[r]),
                32'(2 * blist[r][head[r]].len));
          head[r]++;
          widx[r] = 0;
        end
      end
    end
    clear  = clr;
    enable = ($urandom_range(99) < eprob);
    for (int r = 0; r < 2; r++) begin
      if (bus.grant[r]) begin
        // Owner's command fields are don't-care until DONE.
        bus.req_valid[r] = 1'($urandom_range(1));
        bus.req_len[r*LEN_W +: LEN_W] = 16'($urandom);
        bus.req_exp[r*LEN_W +: LEN_W] = 16'($urandom);
      end else if (head[r] < cnt[r]) begin
        b = blist[r][head[r]];
        bus.req_valid[r] = 1'b1;
        bus.req_len[r*LEN_W +: LEN_W] = 16'(b.len);
        bus.req_exp[r*LEN_W +: LEN_W] = 16'(b.exp);
      end else begin
        bus.req_valid[r] = 1'b0;
        bus.req_len[r*LEN_W +: LEN_W] = 16'($urandom);
        bus.req_exp[r*LEN_W +: LEN_W] = 16'($urandom);
      end
      if (head[r] < cnt[r]) bus.word_data[r*32 +: 32] = gen(r, blist[r][head[r]].id, widx[r]);
      else bus.word_data[r*32 +: 32] = $urandom;
      bus.word_valid[r] = ($urandom_range(99) < vprob);
    end
    #1;
    for (int r = 0; r < 2; r++) hs[r] = bus.word_ready[r] & bus.word_valid[r];
    check((bus.word_ready & ~bus.grant) == 2'b00, "ready_only_granted", 32'(bus.word_ready),
          32'(bus.grant));
    if (!enable) check(bus.word_ready == 2'b00, "ready_when_disabled", 32'(bus.word_ready), 0);
  endtask

  task automatic run(input int vprob, input int eprob, input int budget);
    int n;
    n = 0;
    while ((head[0] < cnt[0] || head[1] < cnt[1]) && n < budget) begin
      step(vprob, eprob, 1'b0);
      n++;
    end
    check(head[0] == cnt[0] && head[1] == cnt[1], "batches_finished", 32'(head[0] + head[1]),
          32'(cnt[0] + cnt[1]));
    check(exp_word.size() == 0, "stream_drained", 32'(exp_word.size()), 32'h0);
  endtask

  vec_t vt [6];
  int   t0;
  int   base;

  initial begin
    vt[0] = '{r: 0, len: 2, exp: 1,      hdr: 32'h0001_0001, nwords: 6, lat: 8};
    vt[1] = '{r: 1, len: 1, exp: 0,      hdr: 32'h0000_0001, nwords: 3, lat: 5};
    vt[2] = '{r: 0, len: 0, exp: 0,      hdr: 32'h0000_0000, nwords: 1, lat: 3};
    vt[3] = '{r: 1, len: 0, exp: 5,      hdr: 32'h0001_0005, nwords: 2, lat: 4};
    vt[4] = '{r: 0, len: 3, exp: 'hffff, hdr: 32'h0001_ffff, nwords: 8, lat: 10};
    vt[5] = '{r: 1, len: 4, exp: 0,      hdr: 32'h0000_0004, nwords: 9, lat: 11};

    checks = 0;
    errors = 0;
    cyc = 0;
    next_id = 1;
    model_last = 1;
    for (int r = 0; r < 2; r++) begin
      head[r] = 0;
      cnt[r]  = 0;
      widx[r] = 0;
      hs[r]   = 1'b0;
    end
    clear = 1'b1;
    enable = 1'b1;
    bus.req_valid = '0;
    bus.req_len = '0;
    bus.req_exp = '0;
    bus.word_data = '0;
    bus.word_valid = '0;
    repeat (2) @(negedge clk);
    check(bus.grant == 2'b00, "reset_grant", 32'(bus.grant), 0);
    check(bus.done == 2'b00, "reset_done", 32'(bus.done), 0);
    check(bus.iface_data == 32'h0, "reset_data", bus.iface_data, 0);
    check(bus.iface_enable == 1'b0, "reset_enable", 32'(bus.iface_enable), 0);
    check(bus.word_ready == 2'b00, "reset_ready", 32'(bus.word_ready), 0);

    // Contention from reset: requester 0 first, then strict alternation.
    add_batch(0, 1, 0);
    add_batch(1, 1, 0);
    add_batch(0, 1, 0);
    add_batch(1, 1, 0);
    plan();
    check(exp_done.size() == 4 && exp_done[0] == 0 && exp_done[1] == 1 && exp_done[2] == 0,
          "rr_plan", 32'(exp_done[0]), 0);
    run(100, 100, 100);

    for (int i = 0; i < 6; i++) begin
      add_batch(vt[i].r, vt[i].len, vt[i].exp);
      plan();
      en_count = 0;
      done_cyc = -1;
      t0 = cyc + 1;
      run(100, 100, 100);
      check(first_word == vt[i].hdr, "vec_first_word", first_word, vt[i].hdr);
      check(en_count == vt[i].nwords, "vec_word_count", 32'(en_count), 32'(vt[i].nwords));
      check(done_cyc - t0 == vt[i].lat, "vec_done_latency", 32'(done_cyc - t0),
            32'(vt[i].lat));
    end

    // Bubbles: word_valid 1,0,0,1 once streaming.
    add_batch(1, 1, 0);
    plan();
    t0 = cyc + 1;
    base = hist_en.size();
    step(100, 100, 1'b0);
    step(100, 100, 1'b0);
    step(100, 100, 1'b0);
    step(0, 100, 1'b0);
    step(0, 100, 1'b0);
    step(100, 100, 1'b0);
    run(100, 100, 20);
    check(hist_en[base + 3] == 1'b1 && hist_en[base + 4] == 1'b0 && hist_en[base + 5] == 1'b0
          && hist_en[base + 6] == 1'b1, "bubble_enable_pattern",
          32'({hist_en[base + 3], hist_en[base + 4], hist_en[base + 5], hist_en[base + 6]}),
          32'h9);
    check(hist_data[base + 4] == 32'h0 && hist_data[base + 5] == 32'h0, "bubble_data_zero",
          hist_data[base + 4] | hist_data[base + 5], 0);
    check(done_cyc - t0 == 7, "bubble_done_latency", 32'(done_cyc - t0), 32'd7);

    // Enable freeze for 3 cycles mid-stream.
    add_batch(0, 3, 0);
    plan();
    t0 = cyc + 1;
    base = hist_en.size();
    repeat (4) step(100, 100, 1'b0);
    repeat (3) step(100, 0, 1'b0);
    run(100, 100, 40);
    for (int k = 5; k < 8; k++) begin
      check(hist_en[base + k] == 1'b0 && hist_data[base + k] == 32'h0, "freeze_outputs",
            hist_data[base + k], 0);
    end
    check(done_cyc - t0 == 12, "freeze_done_latency", 32'(done_cyc - t0), 32'd12);

    // Clear mid-batch abandons the batch without a done pulse.
    add_batch(0, 4, 0);
    plan();
    repeat (4) step(100, 100, 1'b0);
    step(100, 100, 1'b1);
    abandon(0);
    step(100, 100, 1'b0);
    check(bus.grant == 2'b00 && bus.done == 2'b00, "clear_grant_done",
          32'({bus.grant, bus.done}), 0);
    check(bus.iface_enable == 1'b0 && bus.iface_data == 32'h0, "clear_iface",
          bus.iface_data, 0);
    check(bus.word_ready == 2'b00, "clear_ready", 32'(bus.word_ready), 0);
    repeat (3) step(100, 100, 1'b0);
    add_batch(1, 1, 0);
    add_batch(0, 1, 0);
    plan();
    check(exp_done[0] == 0, "post_clear_tie", 32'(exp_done[0]), 0);
    run(100, 100, 40);
    step(100, 100, 1'b1);
    abandon(0);
    add_batch(1, 2, 3);
    plan();
    run(100, 100, 40);

    // Randomized traffic with bubbles and enable drops.
    for (int round = 0; round < 3; round++) begin
      for (int b = 0; b < 8; b++) begin
        add_batch(b % 2, $urandom_range(5),
                  ($urandom_range(1) == 1) ? int'($urandom_range(65535, 1)) : 0);
      end
      plan();
      run(70, 85, 3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/op_stream_arbiter.md
Name: op_stream_arbiter

Overview:
- Shares the single `data_in`/`enable` port of `data_interface` between two command requesters. Each requester is, for example, a weight loader or a training-step sequencer.
- For each granted batch the block emits the framing words `data_interface` expects:
  - optional expected-output header (type 1);
  - operation-count header (type 0);
  - the op/data word pairs.
- It gates the interface's enable so the interface stalls whenever the source has no word ready.
- It arbitrates round-robin at batch granularity; batches are never interleaved.

Parameters:
- NREQ, 2, number of requesters (fixed at 2; vectors below are sized for 2).
- LEN_W, 16, width of the batch pair count and of the expected-output count.

Ports:
- clk  input  1  global clock
- clear  input  1  synchronous active-high reset
- enable  input  1  global enable; when low the FSM and all counters hold
- req_valid  input  2  requester i has a batch pending
- req_len  input  32  {len1,len0}: number of op/data pairs per batch
- req_exp  input  32  {exp1,exp0}: expected output count; 0 = send no type-1 header
- word_data  input  64  {w1,w0}: next stream word from requester i
- word_valid  input  2  word_data[i] valid
- word_ready  output  2  pop strobe to requester i (combinational)
- grant  output  2  one-hot; requester i owns the interface
- done  output  2  one-cycle pulse; batch of requester i fully sent
- iface_data  output  32  drives `data_interface` data_in
- iface_enable  output  1  drives `data_interface` enable

Behaviour:
- Reset (clear=1 at a clock edge):
  - state=IDLE; grant=0; done=0; iface_data=0; iface_enable=0.
  - words_left=0; last_grant=1, so requester 0 wins the first tie.
  - A clear mid-batch abandons the batch. Words already sent are not replayed, and no done pulse is issued.
- enable=0: state, counters and grant hold; iface_enable<=0; iface_data<=0; word_ready=0.
- FSM states: IDLE, HDR_EXP, HDR_CNT, STREAM, DONE. All transitions below require enable=1.
- IDLE:
  - If any req_valid is set, pick the winner. When both are valid, the winner is the requester != last_grant.
  - Latch len and exp; set grant[winner]; last_grant<=winner.
  - Next state is HDR_EXP if exp!=0, else HDR_CNT.
  - iface_enable<=0.
- HDR_EXP:
  - iface_data<={12'h0,4'h1,exp}; iface_enable<=1; next HDR_CNT.
- HDR_CNT:
  - iface_data<={12'h0,4'h0,len}; iface_enable<=1.
  - words_left<=2*len, 17 bits with no overflow.
  - Next state is STREAM if len!=0, else DONE.
- STREAM:
  - word_ready[g]=grant[g] & enable (combinational); word_ready of the non-granted requester is 0.
  - On handshake (word_valid[g] & word_ready[g]): iface_data<=word_data[g]; iface_enable<=1; words_left<=words_left-1.
  - On the handshake where words_left==1, go to DONE.
  - Without a handshake: iface_enable<=0 and iface_data<=0, which stalls the interface (bubble).
- DONE:
  - done[g]<=1 for one cycle; grant<=0; iface_enable<=0; next IDLE.
  - A requester still valid is re-evaluated in IDLE on the following cycle. Minimum gap between batches: 2 cycles.
- Latency:
  - req_valid sampled in IDLE at edge T.
  - grant visible after T.
  - First header on iface_data/iface_enable after edge T+1.
  - Each stream word appears one cycle after its handshake.
- Sampling rules:
  - req_len and req_exp are sampled only at grant; later changes, or deassertion of req_valid, are ignored until DONE.
  - A len larger than 2^LEN_W−1 is impossible by width.
- Invariants:
  - grant is always one-hot or zero.
  - The header words' low nibble never equals 2 or 3 unless len/exp bits make it so. The interface decodes headers only via [19:16], so this is harmless.

Test Plan:
- Single batch: req0 valid, len=2, exp=1, four words A,B,C,D offered back-to-back. Required iface stream: 0x00010001, 0x00000002, A, B, C, D on consecutive cycles with iface_enable=1; then done[0] pulses one cycle later; grant returns to 0.
- Contention round-robin: both requesters valid from reset with len=1, exp=0. Required order:
  - req0 batch: 0x00000001, w0a, w0b;
  - then req1 batch;
  - then req0 again.
  - grant is never two-hot, and no req1 word appears while grant[0]=1.
- Bubbles: req1 len=1 with word_valid toggling 1,0,0,1. Required: iface_enable pattern shows the two-cycle gap with iface_data=0 during the gap; words_left decrements only on handshakes.
- Zero length: req0 len=0, exp=0. Required: a single header 0x00000000 with iface_enable=1, no word_ready pulse, and done[0] on the following cycle.
- Enable freeze: drop enable for 3 cycles mid-STREAM. Required: iface_enable=0, word_ready=0, state and counters unchanged; the stream resumes with the next word on re-enable.
- Clear mid-batch: assert clear during STREAM of a len=4 batch. Required: the next cycle shows all outputs 0 and state IDLE, with no done pulse. A fresh req1 is granted first only if req0 is not also valid, since after reset last_grant=1 and a tie goes to req0.
